// File: rtl/instr_mem_responder_if.sv
// instr_mem_responder_if: CPU fetch bus plus program-loader write port.
//   master : CPU/loader side, drives READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA
//            and observes INSTRUCTION, BUSYWAIT, ERR.
//   slave  : memory responder side, the mirror image.
interface instr_mem_responder_if;
    logic        READ;
    logic [31:0] ADDRESS;
    logic        LOAD_EN;
    logic [9:0]  LOAD_ADDR;
    logic [7:0]  LOAD_DATA;
    logic [31:0] INSTRUCTION;
    logic        BUSYWAIT;
    logic        ERR;

    modport master (
        output READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
        input  INSTRUCTION, BUSYWAIT, ERR
    );

    modport slave (
        input  READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
        output INSTRUCTION, BUSYWAIT, ERR
    );
endinterface

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: byte-addressed instruction memory with a fixed-latency
// fetch handshake and a byte-wide program-loader port.
//   CLK    : single clock, rising edge
//   RESET  : synchronous, active-high; clears FSM and output registers only
//   bus    : slave side of instr_mem_responder_if
//            READ/ADDRESS in, BUSYWAIT out (combinational stall),
//            INSTRUCTION/ERR out (registered, updated only at capture),
//            LOAD_EN/LOAD_ADDR/LOAD_DATA byte writes, honoured in every state.
module instr_mem_responder #(
    parameter int MEM_BYTES    = 1024,
    parameter int READ_LATENCY = 3      // 1..15
) (
    input  logic                 CLK,
    input  logic                 RESET,
    instr_mem_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

    logic [7:0]  mem [MEM_BYTES];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;

    logic          cap_ok;
    logic [AW-1:0] idx0;
    logic [31:0]   word;
    logic [AW-1:0] ld_idx;
    logic          ld_ok;

    // Storage has no reset: program images survive a CPU reset.
    always_comb begin
        ld_idx = AW'(bus.LOAD_ADDR);
        ld_ok  = bus.LOAD_EN && (33'(bus.LOAD_ADDR) < 33'(MEM_BYTES));
    end

    always_ff @(posedge CLK) begin
        if (ld_ok) begin
            mem[ld_idx] <= bus.LOAD_DATA;
        end
    end

    // Word read uses the current array contents, so a loader write landing on
    // the capture edge is not visible to that capture.
    always_comb begin
        cap_ok = (a_q[1:0] == 2'b00) && (({1'b0, a_q} + 33'd3) < 33'(MEM_BYTES));
        idx0   = a_q[AW-1:0];
        word   = {mem[idx0 + AW'(3)], mem[idx0 + AW'(2)],
                  mem[idx0 + AW'(1)], mem[idx0]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        instr_d = instr_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.READ) begin
                    a_d     = bus.ADDRESS;
                    cnt_d   = CNT_INIT;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!bus.READ) begin
                    // CPU withdrew the request: drop it, outputs untouched.
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    instr_d = cap_ok ? word : 32'h0000_0000;
                    err_d   = !cap_ok;
                    state_d = S_RESP;
                end
            end
            // One-cycle response, then a forced idle bubble.
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            instr_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    assign bus.BUSYWAIT    = bus.READ && (state_q != S_RESP);
    assign bus.INSTRUCTION = instr_q;
    assign bus.ERR         = err_q;
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: scoreboard bench for instr_mem_responder.
// Driver issues fetches and pushes expected {ERR, INSTRUCTION} from a byte-array
// model; monitor pops and compares whenever the DUT shows READ && !BUSYWAIT,
// and otherwise checks that the outputs hold their last value.
module tb_instr_mem_responder;
    localparam int MEM = 1024;
    localparam int LAT = 3;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    instr_mem_responder_if bus ();

    instr_mem_responder #(.MEM_BYTES(MEM), .READ_LATENCY(LAT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [7:0]  model [MEM];
    exp_t        q [$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_instr = 32'd0;
    logic        last_err   = 1'b0;
    bit          mon_on     = 1'b0;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: little-endian word from the byte model; misaligned or any
    // byte past the end of memory is a fault with a zero word.
    function automatic exp_t ref_fetch(input logic [31:0] a);
        exp_t r;
        longint unsigned ua = 64'(a);
        if (a[1:0] != 2'b00 || ua + 3 >= MEM) begin
            r.instr = 32'h0;
            r.err   = 1'b1;
        end else begin
            r.instr = {model[int'(ua) + 3], model[int'(ua) + 2],
                       model[int'(ua) + 1], model[int'(ua)]};
            r.err   = 1'b0;
        end
        return r;
    endfunction

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (mon_on) begin
                if (bus.READ && !bus.BUSYWAIT) begin
                    if (q.size() == 0) begin
                        chk("unexpected_resp", 33'd1, 33'd0);
                    end else begin
                        e = q.pop_front();
                        chk("resp", {bus.ERR, bus.INSTRUCTION}, {e.err, e.instr});
                        last_instr = e.instr;
                        last_err   = e.err;
                    end
                end else begin
                    chk("hold", {bus.ERR, bus.INSTRUCTION}, {last_err, last_instr});
                end
            end
        end
    end

    task automatic load(input int a, input logic [7:0] d);
        @(negedge CLK);
        bus.LOAD_EN   = 1'b1;
        bus.LOAD_ADDR = 10'(a);
        bus.LOAD_DATA = d;
        model[a]      = d;
        @(posedge CLK);
        #1 bus.LOAD_EN = 1'b0;
    endtask

    // Count stall cycles from now (inputs already driven) to the RESP cycle.
    task automatic wait_resp(input bit chg, input logic [31:0] alt, input bit wr);
        int cycles = 0;
        while (bus.BUSYWAIT && cycles < 64) begin
            cycles++;
            if (chg && cycles == 2) bus.ADDRESS = alt;
            if (wr && cycles == LAT + 1) begin
                bus.LOAD_EN   = 1'b1;
                bus.LOAD_ADDR = 10'd0;
                bus.LOAD_DATA = 8'hAA;
            end
            @(negedge CLK);
            #1;
            bus.LOAD_EN = 1'b0;
        end
        if (wr) model[0] = 8'hAA;
        chk("latency", 33'(cycles), 33'(LAT + 1));
    endtask

    task automatic fetch(input logic [31:0] addr, input bit chg = 1'b0,
                         input logic [31:0] alt = 32'd0, input bit wr = 1'b0);
        @(negedge CLK);
        bus.READ    = 1'b1;
        bus.ADDRESS = addr;
        q.push_back(ref_fetch(addr));
        #1;
        wait_resp(chg, alt, wr);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            bus.READ = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        RESET         = 1'b1;
        bus.READ      = 1'b0;
        bus.ADDRESS   = 32'd0;
        bus.LOAD_EN   = 1'b0;
        bus.LOAD_ADDR = 10'd0;
        bus.LOAD_DATA = 8'd0;
        for (int i = 0; i < MEM; i++) model[i] = 8'($urandom);

        // Memory is not reset: preload everything (loader works under reset).
        for (int i = 0; i < MEM; i++) load(i, model[i]);
        @(negedge CLK);
        #1;
        chk("reset_instr", {1'b0, bus.INSTRUCTION}, 33'd0);
        chk("reset_err", 33'(bus.ERR), 33'd0);
        chk("reset_busy_read0", 33'(bus.BUSYWAIT), 33'd0);
        bus.READ = 1'b1;
        #1;
        chk("reset_busy_read1", 33'(bus.BUSYWAIT), 33'd1);
        bus.READ = 1'b0;
        load(100, 8'h5A);
        @(negedge CLK);
        RESET  = 1'b0;
        mon_on = 1'b1;

        // Basic fetch
        load(0, 8'h05); load(1, 8'h00); load(2, 8'h04); load(3, 8'h00);
        fetch(32'd0);
        idle(2);

        // Back-to-back
        load(8, 8'h02); load(9, 8'h04); load(10, 8'h06); load(11, 8'h02);
        fetch(32'd0);
        fetch(32'd8);
        idle(1);

        // Faults and boundaries
        fetch(32'd2);    idle(1);
        fetch(32'd1024); idle(1);
        fetch(32'd1022); idle(1);
        fetch(32'd1020); idle(1);
        fetch(32'hFFFF_FFFC); idle(1);
        fetch(32'd100);  idle(1);
        fetch(32'd0);    idle(1);

        // Abort after one FETCH cycle: no response, outputs untouched
        @(negedge CLK); bus.READ = 1'b1; bus.ADDRESS = 32'd8;
        @(negedge CLK);
        @(negedge CLK); bus.READ = 1'b0;
        repeat (LAT + 2) @(negedge CLK);
        #1;
        chk("abort_hold", {bus.ERR, bus.INSTRUCTION}, {1'b0, 32'h0004_0005});

        // Address change after acceptance is ignored
        fetch(32'd0, 1'b1, 32'd8);
        idle(1);

        // Reset mid-FETCH with READ held, request re-accepted after release
        @(negedge CLK); bus.READ = 1'b1; bus.ADDRESS = 32'd8;
        @(negedge CLK);
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK);
        last_instr = 32'd0;
        last_err   = 1'b0;
        #1;
        chk("midfetch_rst_instr", {1'b0, bus.INSTRUCTION}, 33'd0);
        chk("midfetch_rst_err", 33'(bus.ERR), 33'd0);
        chk("rst_busy_follows_read", 33'(bus.BUSYWAIT), 33'd1);
        RESET = 1'b0;
        q.push_back(ref_fetch(32'd8));
        wait_resp(1'b0, 32'd0, 1'b0);
        idle(1);

        // Loader write on the capture edge
        fetch(32'd0, 1'b0, 32'd0, 1'b1);
        idle(1);
        fetch(32'd0);
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
                for (int k = 0; k < 3; k++) load($urandom_range(0, MEM - 1), 8'($urandom));
            end
            case ($urandom_range(0, 9))
                0:       ra = 32'($urandom_range(0, MEM - 1)) | 32'd1;
                1:       ra = 32'(MEM - 8 + 4 * $urandom_range(0, 3));
                2:       ra = $urandom;
                default: ra = 32'(4 * $urandom_range(0, MEM / 4 - 1));
            endcase
            fetch(ra, ($urandom_range(0, 4) == 0), $urandom);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        chk("queue_drained", 33'(q.size()), 33'd0);
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
